// File: rtl/mseq_burst_sched_if.sv
// Control and sample bus of the M-sequence burst scheduler.
// The system controller is the master; the scheduler is the slave.
interface mseq_burst_sched_if;
   logic        start;
   logic        stop;
   logic [7:0]  burst_num;
   logic [15:0] gap_len;
   logic        busy;
   logic        done;
   logic        chip_valid;
   logic        chip;
   logic        period_end;
   logic [31:0] Signal_Send;

   modport master (
      output start, stop, burst_num, gap_len,
      input  busy, done, chip_valid, chip, period_end, Signal_Send
   );

   modport slave (
      input  start, stop, burst_num, gap_len,
      output busy, done, chip_valid, chip, period_end, Signal_Send
   );
endinterface

// File: rtl/mseq_burst_sched.sv
// Burst scheduler: emits whole periods of a maximal-length LFSR chip
// stream, each followed by a silent gap, for a programmable number of
// bursts (0 = continuous until stop). Chips map to +/-AMP samples.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start; config latched on acceptance
// LOAD   | one zero-sample cycle, LFSR <- SEED, chip counter cleared
// RUN    | one chip per cycle, P chips per period
// GAP    | gap_len silent cycles after a period
// FIN    | one-cycle done pulse, then IDLE
//
// All outputs come from flops whose next value is derived from the next
// state, so each output lines up with the state it describes.
module mseq_burst_sched #(
   parameter int               ORDER = 7,
   parameter logic [ORDER-1:0] TAPS  = 7'b0000011,
   parameter logic [ORDER-1:0] SEED  = 7'b1111111,
   parameter logic [31:0]      AMP   = 32'd1000
) (
   input  logic              clk,
   input  logic              rst_n,
   mseq_burst_sched_if.slave bus
);

   localparam logic [ORDER-1:0] CNT_LAST = ORDER'((2 ** ORDER) - 2);
   localparam logic [31:0]      NEG_AMP  = ~AMP + 32'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_GAP,
      S_FIN
   } state_t;

   state_t           state_q, state_d;
   logic [ORDER-1:0] lfsr_q, lfsr_d;
   logic [ORDER-1:0] chip_cnt_q, chip_cnt_d;
   logic [7:0]       burst_cnt_q, burst_cnt_d;
   logic [15:0]      gap_cnt_q, gap_cnt_d;
   logic [7:0]       burst_num_q, burst_num_d;
   logic [15:0]      gap_len_q, gap_len_d;

   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             chip_valid_q, chip_valid_d;
   logic             chip_q, chip_d;
   logic             period_end_q, period_end_d;
   logic [31:0]      sample_q, sample_d;

   logic [7:0]       burst_inc;
   logic             last_after_inc;
   logic             last_now;

   assign burst_inc      = burst_cnt_q + 8'd1;
   assign last_after_inc = (burst_num_q != 8'd0) && (burst_inc == burst_num_q);
   assign last_now       = (burst_num_q != 8'd0) && (burst_cnt_q == burst_num_q);

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      chip_cnt_d  = chip_cnt_q;
      burst_cnt_d = burst_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      burst_num_d = burst_num_q;
      gap_len_d   = gap_len_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.stop) begin
               burst_num_d = bus.burst_num;
               gap_len_d   = bus.gap_len;
               burst_cnt_d = 8'd0;
               state_d     = S_LOAD;
            end
         end
         S_LOAD: begin
            lfsr_d     = SEED;
            chip_cnt_d = '0;
            state_d    = S_RUN;
         end
         S_RUN: begin
            lfsr_d = {^(lfsr_q & TAPS), lfsr_q[ORDER-1:1]};
            if (chip_cnt_q == CNT_LAST) begin
               burst_cnt_d = burst_inc;
               if (gap_len_q != 16'd0) begin
                  gap_cnt_d = 16'd0;
                  state_d   = S_GAP;
               end else begin
                  state_d = last_after_inc ? S_FIN : S_LOAD;
               end
            end else begin
               chip_cnt_d = chip_cnt_q + ORDER'(1);
            end
         end
         S_GAP: begin
            if (gap_cnt_q == gap_len_q - 16'd1) begin
               state_d = last_now ? S_FIN : S_LOAD;
            end else begin
               gap_cnt_d = gap_cnt_q + 16'd1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides everything, including a same-cycle start.
      if (bus.stop) begin
         state_d = S_IDLE;
      end

      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_FIN);
      chip_valid_d = (state_d == S_RUN);
      chip_d       = (state_d == S_RUN) ? lfsr_d[0] : 1'b0;
      period_end_d = (state_d == S_RUN) && (chip_cnt_d == CNT_LAST);
      if (state_d == S_RUN) begin
         sample_d = lfsr_d[0] ? AMP : NEG_AMP;
      end else begin
         sample_d = 32'd0;
      end
   end

   // State, counters, latched config and outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         lfsr_q       <= SEED;
         chip_cnt_q   <= '0;
         burst_cnt_q  <= 8'd0;
         gap_cnt_q    <= 16'd0;
         burst_num_q  <= 8'd0;
         gap_len_q    <= 16'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         chip_valid_q <= 1'b0;
         chip_q       <= 1'b0;
         period_end_q <= 1'b0;
         sample_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         chip_cnt_q   <= chip_cnt_d;
         burst_cnt_q  <= burst_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         burst_num_q  <= burst_num_d;
         gap_len_q    <= gap_len_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         chip_valid_q <= chip_valid_d;
         chip_q       <= chip_d;
         period_end_q <= period_end_d;
         sample_q     <= sample_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.chip_valid  = chip_valid_q;
   assign bus.chip        = chip_q;
   assign bus.period_end  = period_end_q;
   assign bus.Signal_Send = sample_q;

endmodule

// File: tb/tb_mseq_burst_sched.sv
// Scoreboard bench for mseq_burst_sched: stimulus pushes expected chips
// and done timing into queues; a negedge monitor pops and compares.
module tb_mseq_burst_sched;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mseq_burst_sched_if bus ();

   mseq_burst_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit chip;
      bit pend;
   } exp_t;

   exp_t exp_q[$];
   int   done_q[$];
   bit   log_q[$];
   bit   seq[127];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int t0      = 0;
   int vcnt    = 0;
   int bcnt    = 0;
   int dcnt    = 0;
   int ones    = 0;
   int first_lat = 0;
   bit done_prev = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every presented chip and every done pulse.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         done_prev = 1'b0;
      end else begin
         if (bus.chip_valid) begin
            vcnt++;
            if (vcnt == 1) first_lat = cyc + 1 - t0;
            log_q.push_back(bus.chip);
            if (bus.chip) ones++;
            if (exp_q.size() == 0) begin
               chk("unexpected_chip", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("chip", bus.chip, e.chip);
               chk("period_end", bus.period_end, e.pend);
               chk("sample", $signed(bus.Signal_Send), e.chip ? 1000 : -1000);
            end
         end else begin
            chk("zero_sample", $signed(bus.Signal_Send), 0);
            chk("pend_outside_run", bus.period_end, 0);
         end
         if (bus.busy) bcnt++;
         if (done_prev) chk("busy_after_done", bus.busy, 0);
         done_prev = bus.done;
         if (bus.done) begin
            dcnt++;
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_cycle", cyc + 1 - t0, done_q.pop_front());
         end
      end
   end

   task automatic push_periods(input int n);
      for (int p = 0; p < n; p++)
         for (int i = 0; i < 127; i++)
            exp_q.push_back('{chip: seq[i], pend: (i == 126)});
   endtask

   task automatic start_run(input int b, input int g);
      @(negedge clk);
      vcnt = 0; bcnt = 0; dcnt = 0; ones = 0; first_lat = 0;
      log_q.delete();
      bus.burst_num = 8'(b);
      bus.gap_len   = 16'(g);
      bus.start     = 1'b1;
      t0 = cyc + 1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_vcnt(input string name, input int target, input int budget);
      int k = 0;
      while (vcnt < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, vcnt >= target, 1);
   endtask

   task automatic wait_done(input string name, input int budget);
      int k = 0;
      while (done_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, done_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_first14(input string name);
      logic [13:0] v = '0;
      if (log_q.size() < 14) begin
         chk({name, "_len"}, log_q.size(), 14);
      end else begin
         for (int i = 0; i < 14; i++) v = {v[12:0], log_q[i]};
         chk(name, v, 14'b11111110000001);
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int bad;
      int v_at_stop;

      // Reference chip stream from the recurrence c[n+7] = c[n] ^ c[n+1].
      for (int i = 0; i < 7; i++) seq[i] = 1'b1;
      for (int n = 0; n < 120; n++) seq[n+7] = seq[n] ^ seq[n+1];

      bus.start = 1'b0; bus.stop = 1'b0;
      bus.burst_num = 8'd0; bus.gap_len = 16'd0;

      // Reset held for 100 cycles, with a start request during it.
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         bus.start = (i >= 40 && i < 45);
         if (bus.Signal_Send != 32'd0 || bus.busy || bus.done || bus.chip_valid) bad++;
      end
      bus.start = 1'b0;
      chk("reset_bad_cycles", bad, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_busy_after_reset", bus.busy, 0);

      // Single burst, no gap.
      push_periods(1);
      done_q.push_back(129);
      start_run(1, 0);
      wait_done("done_single", 400);
      chk("first_chip_latency", first_lat, 2);
      chk_first14("first14_single");
      chk("ones_single", ones, 64);
      chk("chips_single", vcnt, 127);
      chk("busy_cycles_single", bcnt, 129);

      // Three bursts with gap 5; a start (with new config) during the run is ignored.
      push_periods(3);
      done_q.push_back(400);
      start_run(3, 5);
      wait_vcnt("wait_burst2", 127 + 60, 600);
      @(negedge clk);
      bus.burst_num = 8'd9; bus.gap_len = 16'd0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("done_multi", 800);
      chk("chips_multi", vcnt, 381);
      chk("ones_multi", ones, 192);
      chk("busy_cycles_multi", bcnt, 400);
      chk("done_count_multi", dcnt, 1);

      // Continuous mode, then stop mid-RUN.
      push_periods(11);
      start_run(0, 2);
      wait_vcnt("wait_10_periods", 10 * 127 + 40, 2000);
      chk("no_done_continuous", dcnt, 0);
      @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      chk("stop_busy", bus.busy, 0);
      chk("stop_sample", bus.Signal_Send, 0);
      chk("stop_valid", bus.chip_valid, 0);
      chk("stop_done", bus.done, 0);
      v_at_stop = vcnt;
      repeat (5) @(negedge clk);
      chk("no_done_after_stop", dcnt, 0);
      chk("no_chips_after_stop", vcnt, v_at_stop);
      exp_q.delete();

      // start and stop together in IDLE.
      @(negedge clk);
      bus.burst_num = 8'd1; bus.gap_len = 16'd0;
      bus.start = 1'b1; bus.stop = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.busy || bus.chip_valid) bad++;
      end
      chk("start_stop_idle", bad, 0);

      // Reset during chip 50, then a fresh run.
      push_periods(1);
      start_run(1, 0);
      wait_vcnt("wait_chip50", 50, 200);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_sample", bus.Signal_Send, 0);
      chk("rstmid_busy", bus.busy, 0);
      chk("rstmid_valid", bus.chip_valid, 0);
      chk("rstmid_pend", bus.period_end, 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      push_periods(1);
      done_q.push_back(129);
      start_run(1, 0);
      wait_done("done_after_rst", 400);
      chk_first14("first14_after_rst");
      chk("ones_after_rst", ones, 64);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
